// File: rtl/hdmi_in_pkg.sv
// Shared constants and pixel packing for the HDMI ingress path.
// Pixel formats, luma weights and the fixed pipeline latency live here.
package hdmi_in_pkg;

    localparam int unsigned LAT = 3;

    localparam logic [1:0] FMT_RGB565 = 2'b00;
    localparam logic [1:0] FMT_GRAY8  = 2'b01;
    localparam logic [1:0] FMT_RGB444 = 2'b10;

    localparam logic [7:0] COEF_R = 8'd77;
    localparam logic [7:0] COEF_G = 8'd150;
    localparam logic [7:0] COEF_B = 8'd29;

    // Takes only the colour bits any format needs; 444 reuses the top of the 565 fields.
    function automatic logic [15:0] fmt_pack(input logic [1:0] fmt,
                                             input logic [4:0] r5,
                                             input logic [5:0] g6,
                                             input logic [4:0] b5,
                                             input logic [7:0] luma);
        logic [15:0] v;
        case (fmt)
            FMT_GRAY8:  v = {8'h00, luma};
            FMT_RGB444: v = {4'h0, r5[4:1], g6[5:2], b5[4:1]};
            FMT_RGB565: v = {r5, g6, b5};
            default:    v = {r5, g6, b5};
        endcase
        return v;
    endfunction

endpackage

// File: rtl/rgb_fmt_conv.sv
// Two-stage RGB888 to 16-bit pixel converter: luma products first, then sum and pack.
// data_out is forced to zero whenever the pixel is not valid.
module rgb_fmt_conv
    import hdmi_in_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [1:0]  fmt_in,
    input  logic [7:0]  red_in,
    input  logic [7:0]  green_in,
    input  logic [7:0]  blue_in,
    output logic        valid_out,
    output logic [15:0] data_out
);

    logic        r_valid_a;
    logic [1:0]  r_fmt_a;
    logic [4:0]  r_red_a;
    logic [5:0]  r_grn_a;
    logic [4:0]  r_blu_a;
    logic [15:0] r_prod_r;
    logic [15:0] r_prod_g;
    logic [15:0] r_prod_b;

    logic [15:0] w_sum;
    logic [7:0]  w_luma;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_a <= 1'b0;
            r_fmt_a   <= FMT_RGB565;
            r_red_a   <= '0;
            r_grn_a   <= '0;
            r_blu_a   <= '0;
            r_prod_r  <= '0;
            r_prod_g  <= '0;
            r_prod_b  <= '0;
        end else begin
            r_valid_a <= valid_in;
            r_fmt_a   <= fmt_in;
            r_red_a   <= red_in[7:3];
            r_grn_a   <= green_in[7:2];
            r_blu_a   <= blue_in[7:3];
            r_prod_r  <= {8'h00, red_in} * {8'h00, COEF_R};
            r_prod_g  <= {8'h00, green_in} * {8'h00, COEF_G};
            r_prod_b  <= {8'h00, blue_in} * {8'h00, COEF_B};
        end
    end

    // Weights sum to 256, so the worst case 255*256 still fits in 16 bits.
    assign w_sum  = r_prod_r + r_prod_g + r_prod_b;
    assign w_luma = 8'(w_sum >> 8);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else begin
            valid_out <= r_valid_a;
            data_out  <= r_valid_a ? fmt_pack(r_fmt_a, r_red_a, r_grn_a, r_blu_a, w_luma)
                                   : 16'h0000;
        end
    end

endmodule

// File: rtl/hdmi_video_ingress.sv
// HDMI receive front end: frame decimation, optional 2:1 subsampling and pixel formatting.
// Everything stays in the pixel clock domain with a fixed three-stage latency.
module hdmi_video_ingress
    import hdmi_in_pkg::*;
#(
    parameter int unsigned FDIV_W = 3,
    parameter int unsigned X_W    = 12,
    parameter int unsigned Y_W    = 11
) (
    input  logic              hdmi_pix_clk_in,
    input  logic              rst,
    input  logic [FDIV_W-1:0] frame_div,
    input  logic              scale_en,
    input  logic [1:0]        fmt_sel,
    input  logic [7:0]        red_in,
    input  logic [7:0]        green_in,
    input  logic [7:0]        blue_in,
    input  logic              vs_in,
    input  logic              de_in,
    output logic              vs_out,
    output logic              de_out,
    output logic [15:0]       data_out,
    output logic [X_W-1:0]    x_out,
    output logic [Y_W-1:0]    y_out,
    output logic              sof_out
);

    // Stage 1: input register
    logic              r1_vs;
    logic              r1_de;
    logic [7:0]        r1_red;
    logic [7:0]        r1_grn;
    logic [7:0]        r1_blu;
    logic [FDIV_W-1:0] r1_div;
    logic              r1_scale;
    logic [1:0]        r1_fmt;

    always_ff @(posedge hdmi_pix_clk_in) begin
        if (rst) begin
            r1_vs    <= 1'b0;
            r1_de    <= 1'b0;
            r1_red   <= '0;
            r1_grn   <= '0;
            r1_blu   <= '0;
            r1_div   <= '0;
            r1_scale <= 1'b0;
            r1_fmt   <= FMT_RGB565;
        end else begin
            r1_vs    <= vs_in;
            r1_de    <= de_in;
            r1_red   <= red_in;
            r1_grn   <= green_in;
            r1_blu   <= blue_in;
            r1_div   <= frame_div;
            r1_scale <= scale_en;
            r1_fmt   <= fmt_sel;
        end
    end

    // Frame state
    logic              r_vs_prev;
    logic              r_de_prev;
    logic [FDIV_W-1:0] r_fcnt;
    logic              r_keep;
    logic [FDIV_W-1:0] r_div_sh;
    logic              r_scale_sh;
    logic [1:0]        r_fmt_sh;
    logic [X_W-1:0]    r_xin;
    logic [Y_W-1:0]    r_yin;
    logic              r_sof_pend;

    logic              w_bound;
    logic              w_fall;
    logic              w_scale;
    logic [1:0]        w_fmt;
    logic [FDIV_W-1:0] w_fcnt;
    logic              w_keep;
    logic [X_W-1:0]    w_xcur;
    logic [Y_W-1:0]    w_ycur;
    logic [X_W-1:0]    w_xinc;
    logic [Y_W-1:0]    w_yinc;
    logic [X_W-1:0]    w_xo;
    logic [Y_W-1:0]    w_yo;
    logic              w_pass;
    logic              w_sof;

    assign w_bound = r1_vs & ~r_vs_prev;
    assign w_fall  = r_de_prev & ~r1_de;

    // Shadows load at the boundary, and the boundary pixel already sees the new values.
    assign w_scale = w_bound ? r1_scale : r_scale_sh;
    assign w_fmt   = w_bound ? r1_fmt   : r_fmt_sh;

    always_comb begin
        w_fcnt = r_fcnt;
        w_keep = r_keep;
        if (w_bound) begin
            if (r1_div <= FDIV_W'(1)) begin
                w_fcnt = '0;
            end else if (r_fcnt >= (r1_div - FDIV_W'(1))) begin
                w_fcnt = '0;
            end else begin
                w_fcnt = r_fcnt + FDIV_W'(1);
            end
            w_keep = (w_fcnt == '0);
        end
    end

    assign w_xcur = w_bound ? '0 : r_xin;
    assign w_ycur = w_bound ? '0 : r_yin;
    assign w_xinc = (&w_xcur) ? w_xcur : w_xcur + X_W'(1);
    assign w_yinc = (&w_ycur) ? w_ycur : w_ycur + Y_W'(1);

    assign w_pass = w_keep & r1_de & (~w_scale | (~w_xcur[0] & ~w_ycur[0]));
    assign w_sof  = w_pass & (w_bound | r_sof_pend);
    assign w_xo   = w_scale ? (w_xcur >> 1) : w_xcur;
    assign w_yo   = w_scale ? (w_ycur >> 1) : w_ycur;

    always_ff @(posedge hdmi_pix_clk_in) begin
        if (rst) begin
            r_vs_prev  <= 1'b0;
            r_de_prev  <= 1'b0;
            r_fcnt     <= '0;
            r_keep     <= 1'b0;
            r_div_sh   <= '0;
            r_scale_sh <= 1'b0;
            r_fmt_sh   <= FMT_RGB565;
            r_xin      <= '0;
            r_yin      <= '0;
            r_sof_pend <= 1'b0;
        end else begin
            r_vs_prev  <= r1_vs;
            r_de_prev  <= r1_de;
            r_fcnt     <= w_fcnt;
            r_keep     <= w_keep;
            r_scale_sh <= w_scale;
            r_fmt_sh   <= w_fmt;
            if (w_bound) begin
                r_div_sh <= r1_div;
            end
            if (r1_de) begin
                r_xin <= w_xinc;
            end else if (w_fall) begin
                r_xin <= '0;
            end else begin
                r_xin <= w_xcur;
            end
            r_yin <= w_fall ? w_yinc : w_ycur;
            if (w_bound) begin
                r_sof_pend <= w_keep & ~w_pass;
            end else begin
                r_sof_pend <= r_sof_pend & ~w_pass;
            end
        end
    end

    // Stages 2 and 3 for the side-band signals that travel beside the converter.
    logic [X_W-1:0] r2_x;
    logic [Y_W-1:0] r2_y;
    logic           r2_sof;
    logic [LAT-2:0] r_vs_dly;

    always_ff @(posedge hdmi_pix_clk_in) begin
        if (rst) begin
            r2_x     <= '0;
            r2_y     <= '0;
            r2_sof   <= 1'b0;
            x_out    <= '0;
            y_out    <= '0;
            sof_out  <= 1'b0;
            r_vs_dly <= '0;
        end else begin
            r2_x     <= w_pass ? w_xo : '0;
            r2_y     <= w_pass ? w_yo : '0;
            r2_sof   <= w_sof;
            x_out    <= r2_x;
            y_out    <= r2_y;
            sof_out  <= r2_sof;
            r_vs_dly <= {r_vs_dly[LAT-3:0], r1_vs};
        end
    end

    assign vs_out = r_vs_dly[LAT-2];

    rgb_fmt_conv u_fmt (
        .clk       (hdmi_pix_clk_in),
        .rst       (rst),
        .valid_in  (w_pass),
        .fmt_in    (w_fmt),
        .red_in    (r1_red),
        .green_in  (r1_grn),
        .blue_in   (r1_blu),
        .valid_out (de_out),
        .data_out  (data_out)
    );

endmodule

// File: tb/tb_hdmi_video_ingress.sv
// Randomised and directed bench for hdmi_video_ingress against a frame-level reference model.
// Expected outputs are scheduled three cycles ahead of each driven input cycle.
module tb_hdmi_video_ingress;

    localparam int FDIV_W = 3;
    localparam int X_W    = 12;
    localparam int Y_W    = 11;
    localparam int NCYC   = 8192;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [FDIV_W-1:0] frame_div = '0;
    logic              scale_en = 1'b0;
    logic [1:0]        fmt_sel = 2'b00;
    logic [7:0]        red_in = '0;
    logic [7:0]        green_in = '0;
    logic [7:0]        blue_in = '0;
    logic              vs_in = 1'b0;
    logic              de_in = 1'b0;
    logic              vs_out;
    logic              de_out;
    logic [15:0]       data_out;
    logic [X_W-1:0]    x_out;
    logic [Y_W-1:0]    y_out;
    logic              sof_out;

    hdmi_video_ingress #(
        .FDIV_W (FDIV_W),
        .X_W    (X_W),
        .Y_W    (Y_W)
    ) dut (
        .hdmi_pix_clk_in (clk),
        .rst             (rst),
        .frame_div       (frame_div),
        .scale_en        (scale_en),
        .fmt_sel         (fmt_sel),
        .red_in          (red_in),
        .green_in        (green_in),
        .blue_in         (blue_in),
        .vs_in           (vs_in),
        .de_in           (de_in),
        .vs_out          (vs_out),
        .de_out          (de_out),
        .data_out        (data_out),
        .x_out           (x_out),
        .y_out           (y_out),
        .sof_out         (sof_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected output per cycle
    int e_vs[NCYC];
    int e_de[NCYC];
    int e_sof[NCYC];
    int e_data[NCYC];
    int e_x[NCYC];
    int e_y[NCYC];

    // Reference model state
    int m_keep = 0, m_fcnt = 0, m_div = 0, m_scale = 0, m_fmt = 0, m_pend = 0;
    int c_div = 0, c_scale = 0, c_fmt = 0;
    int use_rand = 0, fr = 0, fg = 0, fb = 0;

    int n_checks = 0, n_fail = 0;
    int cnt_de = 0, cnt_sof = 0, last_data = 0, last_x = 0, last_y = 0;
    int de_out_rise = 0, de_in_rise = 0;
    bit prev_de_out = 0, prev_de_drv = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 'h%0h, expected 'h%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int fmt_model(input int f, input int r, input int g, input int b);
        if (f == 1) return (77 * r + 150 * g + 29 * b) / 256;
        if (f == 2) return (r / 16) * 256 + (g / 16) * 16 + (b / 16);
        return (r / 8) * 2048 + (g / 4) * 32 + (b / 8);
    endfunction

    task automatic set_idle(input int k);
        e_vs[k] = 0; e_de[k] = 0; e_sof[k] = 0; e_data[k] = 0; e_x[k] = 0; e_y[k] = 0;
    endtask

    task automatic model_boundary();
        m_div = c_div; m_scale = c_scale; m_fmt = c_fmt;
        if (m_div <= 1) m_fcnt = 0;
        else if (m_fcnt >= m_div - 1) m_fcnt = 0;
        else m_fcnt = m_fcnt + 1;
        m_keep = (m_fcnt == 0);
        m_pend = m_keep;
    endtask

    task automatic step(input bit vs, input bit de, input bit bnd, input bit rstv,
                        input int r, input int g, input int b, input int row, input int col);
        int k;
        bit pass;
        @(negedge clk);
        rst = rstv; vs_in = vs; de_in = de;
        red_in = r[7:0]; green_in = g[7:0]; blue_in = b[7:0];
        frame_div = c_div[FDIV_W-1:0]; scale_en = c_scale[0]; fmt_sel = c_fmt[1:0];
        if (de && !prev_de_drv) de_in_rise = cyc;
        prev_de_drv = de;
        k = cyc + 3;
        if (k >= NCYC) begin
            $display("FAIL model_index: cycle %0d beyond table size %0d", k, NCYC);
            $fatal(1);
        end
        if (rstv) begin
            m_keep = 0; m_fcnt = 0; m_div = 0; m_scale = 0; m_fmt = 0; m_pend = 0;
            for (int i = 1; i <= 3; i++) set_idle(cyc + i);
        end else begin
            if (bnd) model_boundary();
            pass = (m_keep != 0) && de && (m_scale == 0 || (row % 2 == 0 && col % 2 == 0));
            e_vs[k]   = vs;
            e_de[k]   = pass;
            e_data[k] = pass ? fmt_model(m_fmt, r, g, b) : 0;
            e_x[k]    = (m_scale != 0) ? col / 2 : col;
            e_y[k]    = (m_scale != 0) ? row / 2 : row;
            e_sof[k]  = pass && (m_pend != 0);
            if (pass) m_pend = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic frame(input int w, input int h, input int hb, input int rst_at,
                         input int chg_at, input int chg_div, input int chg_fmt,
                         input int chg_scale);
        int p = 0;
        int r, g, b;
        step(1, 0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        for (int row = 0; row < h; row++) begin
            for (int col = 0; col < w; col++) begin
                if (p == chg_at) begin
                    c_div = chg_div; c_fmt = chg_fmt; c_scale = chg_scale;
                end
                if (use_rand != 0) begin
                    r = $urandom_range(0, 255); g = $urandom_range(0, 255);
                    b = $urandom_range(0, 255);
                end else begin
                    r = fr; g = fg; b = fb;
                end
                step(0, 1, 0, (p == rst_at), r, g, b, row, col);
                p++;
            end
            idle(hb);
        end
        idle(2);
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (cyc < NCYC) begin
                chk("de_out", de_out, e_de[cyc]);
                chk("vs_out", vs_out, e_vs[cyc]);
                chk("sof_out", sof_out, e_sof[cyc]);
                chk("data_out", data_out, e_data[cyc]);
                if (e_de[cyc] != 0) begin
                    chk("x_out", x_out, e_x[cyc]);
                    chk("y_out", y_out, e_y[cyc]);
                end
            end
            if (de_out) begin
                cnt_de++;
                last_data = data_out; last_x = x_out; last_y = y_out;
                if (!prev_de_out) de_out_rise = cyc;
            end
            if (sof_out) cnt_sof++;
            prev_de_out = de_out;
        end
    endtask

    int b_de, b_sof;
    int dec_exp[4];
    int shr_exp[4];

    initial begin
        for (int i = 0; i < NCYC; i++) set_idle(i);
        fork
            compare_loop();
        join_none

        do_reset(3);
        idle(2);
        chk("reset_de_out", de_out, 0);
        chk("reset_data_out", data_out, 0);
        chk("reset_vs_out", vs_out, 0);
        chk("reset_sof_out", sof_out, 0);

        // Decimation by 3: two lead-in frames bring the counter to 2
        use_rand = 0; fr = 'hFF; fg = 'h80; fb = 'h10;
        c_div = 3; c_fmt = 0; c_scale = 0;
        frame(8, 4, 3, -1, -1, 0, 0, 0);
        frame(8, 4, 3, -1, -1, 0, 0, 0);
        dec_exp = '{32, 0, 0, 32};
        b_sof = cnt_sof;
        for (int f = 0; f < 4; f++) begin
            b_de = cnt_de;
            frame(8, 4, 3, -1, -1, 0, 0, 0);
            chk("decim_frame_pixels", cnt_de - b_de, dec_exp[f]);
        end
        chk("decim_sof_count", cnt_sof - b_sof, 2);
        chk("decim_rgb565_data", last_data, 'hFC02);

        // 2:1 subsampling
        use_rand = 1; c_div = 1; c_scale = 1;
        b_de = cnt_de;
        frame(8, 4, 3, -1, -1, 0, 0, 0);
        chk("scale_pixels", cnt_de - b_de, 8);
        chk("scale_last_x", last_x, 3);
        chk("scale_last_y", last_y, 1);

        // Formats
        use_rand = 0; c_scale = 0; c_fmt = 1;
        fr = 'hFF; fg = 'hFF; fb = 'hFF;
        frame(2, 2, 2, -1, -1, 0, 0, 0);
        chk("gray_white", last_data, 'h00FF);
        fr = 'hFF; fg = 0; fb = 0;
        frame(2, 2, 2, -1, -1, 0, 0, 0);
        chk("gray_red", last_data, 'h004C);
        c_fmt = 2; fr = 'hAB; fg = 'hCD; fb = 'hEF;
        frame(2, 2, 2, -1, -1, 0, 0, 0);
        chk("rgb444", last_data, 'h0ACE);

        // Mid-frame config change only takes effect at the next boundary
        c_fmt = 0; c_div = 1;
        b_de = cnt_de;
        frame(4, 2, 2, -1, 3, 3, 1, 0);
        chk("shadow_pixels", cnt_de - b_de, 8);
        chk("shadow_fmt_held", last_data, 'hAE7D);
        b_de = cnt_de;
        frame(4, 2, 2, -1, -1, 0, 0, 0);
        chk("shadow_div_applied", cnt_de - b_de, 0);
        c_div = 1;
        b_de = cnt_de;
        frame(4, 2, 2, -1, -1, 0, 0, 0);
        chk("shadow_next_pixels", cnt_de - b_de, 8);
        chk("shadow_fmt_applied", last_data, 'h00C6);

        // Latency from de_in to de_out
        frame(5, 1, 2, -1, -1, 0, 0, 0);
        chk("latency", de_out_rise - de_in_rise, 3);

        // Reset mid-line: six pixels from the first row survive, the rest drops
        use_rand = 1; c_fmt = 3;
        b_de = cnt_de;
        frame(6, 3, 3, 8, -1, 0, 0, 0);
        chk("rst_midline_pixels", cnt_de - b_de, 6);
        b_de = cnt_de; b_sof = cnt_sof;
        frame(6, 3, 3, -1, -1, 0, 0, 0);
        chk("rst_next_frame_pixels", cnt_de - b_de, 18);
        chk("rst_next_frame_sof", cnt_sof - b_sof, 1);

        // Ratio shrink 7 -> 2 with the counter at 5
        do_reset(2);
        c_div = 7; c_fmt = 0;
        b_de = cnt_de;
        for (int f = 0; f < 5; f++) frame(4, 2, 2, -1, -1, 0, 0, 0);
        chk("shrink_lead_pixels", cnt_de - b_de, 0);
        c_div = 2;
        shr_exp = '{8, 0, 8, 0};
        for (int f = 0; f < 4; f++) begin
            b_de = cnt_de;
            frame(4, 2, 2, -1, -1, 0, 0, 0);
            chk("shrink_frame_pixels", cnt_de - b_de, shr_exp[f]);
        end

        // Random frames, configs, mid-frame changes and occasional resets
        use_rand = 1;
        for (int f = 0; f < 30; f++) begin
            int w, h, hb, ra, ca;
            w  = $urandom_range(1, 9);
            h  = $urandom_range(1, 6);
            hb = $urandom_range(1, 4);
            c_div   = $urandom_range(0, 7);
            c_scale = $urandom_range(0, 1);
            c_fmt   = $urandom_range(0, 3);
            ca = ($urandom_range(0, 2) == 0) ? $urandom_range(0, w * h - 1) : -1;
            ra = ($urandom_range(0, 9) == 0) ? $urandom_range(0, w * h - 1) : -1;
            frame(w, h, hb, ra, ca, $urandom_range(0, 7), $urandom_range(0, 3),
                  $urandom_range(0, 1));
        end

        idle(6);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hdmi_video_ingress.md
# hdmi_video_ingress

Parametrised HDMI receive front end: takes RGB888 pixels with VS/DE from the HDMI receiver and applies run-time frame-rate decimation, optional 2:1 spatial subsampling and a selectable output pixel format. It also emits output-space pixel coordinates and a start-of-frame pulse. It sits between the HDMI receiver and the per-channel frame-buffer write logic of the multi-channel splicer. Outputs stay in the input timing domain, so a RAM/DDR stage is still needed before any VESA output timing.

## Interface
- FDIV_W, 3: width of `frame_div`; maximum ratio is 2^FDIV_W−1.
- X_W, 12: width of the column counter and `x_out`.
- Y_W, 11: width of the row counter and `y_out`.
- `hdmi_pix_clk_in` in 1: pixel clock; the only clock in the block.
- `rst` in 1: synchronous, active-high reset.
- `frame_div` in FDIV_W: keep 1 frame in every `frame_div` frames; 0 and 1 both mean keep every frame.
- `scale_en` in 1: 1 enables 2:1 horizontal and 2:1 vertical subsampling.
- `fmt_sel` in 2: output format. 00 = RGB565, 01 = gray8, 10 = RGB444, 11 = RGB565.
- `red_in`, `green_in`, `blue_in` in 8 each: input pixel components.
- `vs_in` in 1: vertical sync, active high.
- `de_in` in 1: data enable.
- `vs_out` out 1: `vs_in` delayed by LAT.
- `de_out` out 1: output pixel valid; this is the frame-buffer write enable.
- `data_out` out 16: formatted pixel; 0 whenever `de_out`=0.
- `x_out` out X_W: output-space column of the current `de_out` pixel.
- `y_out` out Y_W: output-space row of the current `de_out` pixel.
- `sof_out` out 1: single-cycle pulse coincident with the first `de_out` of each kept frame.

## Operation
**Frame boundary**
- A frame boundary is a `vs_in` rising edge, detected against a registered copy of `vs_in`.
- At each boundary, `frame_div`, `scale_en` and `fmt_sel` are latched into shadow registers. Changes between boundaries are ignored.

**Frame decimation**
- `fcnt` is FDIV_W wide and is updated at each boundary.
- It wraps to 0 when `fcnt >= div_sh−1`; otherwise it increments.
- `keep` is set to 1 when the post-update `fcnt` is 0, else 0.
- With `div_sh` ≤ 1, `keep` is always 1.
- If `div_sh` shrinks below the current `fcnt`, the `>=` compare forces a wrap on the next boundary.

**Input counters**
- `xin` increments on each `de_in`=1 cycle and clears on each `de_in` falling edge.
- `yin` increments on each `de_in` falling edge and clears at a boundary.
- Both counters saturate at their all-ones value and never wrap.

**Pixel pass rule**
- A pixel passes when `keep`=1 and `de_in`=1.
- When `scale_sh`=1, it additionally requires `xin[0]`=0 and `yin[0]`=0.

**Output coordinates**
- `x_out` = `xin`, or `xin>>1` when scaled.
- `y_out` = `yin`, or `yin>>1` when scaled.

**Pixel formats**
- RGB565: `{R[7:3],G[7:2],B[7:3]}`.
- RGB444: `{4'b0,R[7:4],G[7:4],B[7:4]}`.
- gray8: `{8'b0,Y}`, where Y = (77·R + 150·G + 29·B) >> 8.
  - The sum is 16 bits wide; its maximum is 65280, so it cannot overflow.

**Reset**
- After reset, `keep`=0, so the partial frame in progress is dropped. Output begins at the first boundary after reset.

## Timing
- Latency LAT = 3 cycles, fixed for every mode:
  - stage 1: input register;
  - stage 2: products and pass decision;
  - stage 3: sum/format and output register.
- `vs_out`, `de_out`, `data_out`, `x_out`, `y_out` and `sof_out` are all aligned to LAT.
- Reset value of every output is 0. Reset also clears `fcnt`, `keep`, the shadows (div=0, scale=0, fmt=00), the counters and all pipeline stages.
- Reset asserted mid-frame: all outputs read 0 on the cycle after `rst` is sampled high, and stay 0 until a boundary follows reset release.
- Boundary and `de_in` in the same cycle: the counters clear first, and that pixel is evaluated with the new `keep` and shadow values as pixel (0,0).
- `de_in` while `vs_in`=1: processed normally; no special-casing.
- `sof_out` fires once per kept frame, on the first passed pixel. It does not fire for a kept frame that has no passed pixels.

## Structure
- Shared package `hdmi_in_pkg` holds:
  - format encodings FMT_RGB565, FMT_GRAY8, FMT_RGB444;
  - luma coefficients 77, 150 and 29;
  - LAT = 3.
- One sub-module, `rgb_fmt_conv`: a 2-stage pipelined RGB888 → 16-bit converter.
  - Ports: clock, `rst`, valid in/out, `fmt` and RGB in, `data_out`.
- The top level holds the edge detect, frame counter, shadows, counters, pass logic and the delay line for VS/DE/coordinates.

## Test plan
- **Frame decimation:** `frame_div`=3, four 8×4 frames, fmt 00 → `de_out` active only in frames 1 and 4, 32 pulses each; `sof_out` once per kept frame; `data_out` for R=0xFF, G=0x80, B=0x10 is 0xFC02.
- **Scaling and coordinates:** `scale_en`=1, 8×4 frame, `frame_div`=1 → 8 output pixels; `x_out` runs 0..3 and `y_out` runs 0..1; source pixels are the even columns of rows 0 and 2.
- **Formats:** fmt 01 with R=G=B=0xFF → `data_out`=0x00FF; fmt 01 with R=0xFF, G=B=0 → 0x004C; fmt 10 with 0xAB, 0xCD, 0xEF → 0x0ACE.
- **Shadowing and latency:** change `fmt_sel` and `frame_div` mid-frame → the current frame is unchanged and the new values apply from the next boundary; `de_out` trails `de_in` by exactly 3 cycles.
- **Reset mid-operation:** pulse `rst` mid-line → all outputs 0 from the next cycle; the remainder of that frame produces no `de_out`; the next frame is output.
- **Ratio shrink:** `frame_div` 7 → 2 while `fcnt`=5 → wrap at the next boundary, then every second frame is kept.
